onehot_pulse_decoder_16: RTL and testbench
==========================================

ONEHOT_PULSE_DECODER_16 -- requirements
Module: onehot_pulse_decoder_16

Interface
REQ-001 SHALL have parameter: PULSE_LEN, 4, cycles each one-hot output is held (legal 1..255).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: en  input  1  block enable; low aborts activity and blocks acceptance.
REQ-005 SHALL have port: i_valid  input  1  producer presents a code on i.
REQ-006 SHALL have port: i_ready  output  1  block can accept a code this cycle.
REQ-007 SHALL have port: i  input  4  binary code, 0..15, e.g. from a 16x4 priority encoder.
REQ-008 SHALL have port: y  output  16  registered one-hot output, bit i set while driving.
REQ-009 SHALL have port: busy  output  1  high while in DRIVE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse in the final DRIVE cycle of each code.

Function
REQ-011 SHALL implement states IDLE and DRIVE; no other reachable states.
REQ-012 SHALL accept a code on any cycle with i_valid=1 and i_ready=1; in all other cycles i is ignored.
REQ-013 SHALL, in IDLE, drive i_ready = en; y = 16'h0000; busy = 0; done = 0.
REQ-014 SHALL, on acceptance in IDLE, enter DRIVE next cycle with y = 1 << i (latency 1 cycle) and load the hold counter with PULSE_LEN-1.
REQ-015 SHALL, in DRIVE, hold y stable and decrement the counter each cycle; the cycle in which counter = 0 is the final DRIVE cycle, with done = 1.
REQ-016 SHALL, after the final DRIVE cycle with no pending code, return to IDLE with y = 0 on the next cycle.
REQ-017 SHALL, with PULSE_LEN = 1, hold y for exactly one cycle, done asserted in that same cycle.
REQ-018 SHALL assert exactly one bit of y in DRIVE for every code 0..15, including code 0 (y = 16'h0001).
REQ-019 SHALL, when en = 0 on a cycle, return to IDLE on the next cycle with y = 0, busy = 0, pending code discarded, and no done pulse for the aborted code.
REQ-020 SHALL, when en falls during the final DRIVE cycle, still assert done in that cycle and then go IDLE.

Reset
REQ-021 SHALL, on any rising clk edge with rst = 1, set state IDLE, y = 16'h0000, busy = 0, done = 0, counter = 0, pending slot empty.
REQ-022 SHALL force i_ready = 0 while rst = 1; reset SHALL take priority over en and acceptance, including mid-DRIVE.

Configuration
REQ-023 SHALL support macro DEC_QUEUE_EN, enabling a one-entry pending-code slot.
REQ-024 SHALL, without DEC_QUEUE_EN, drive i_ready = 0 throughout DRIVE, giving at least one y = 0 cycle between consecutive codes.
REQ-025 SHALL, with DEC_QUEUE_EN, drive i_ready = en in DRIVE while the slot is empty, store an accepted code in the slot, and drop i_ready while the slot is full.
REQ-026 SHALL, with DEC_QUEUE_EN, load the pending code directly into y on the cycle after the final DRIVE cycle (no gap), reload the counter, stay in DRIVE and empty the slot.
REQ-027 SHALL, with DEC_QUEUE_EN, treat a code accepted during the final DRIVE cycle as pending, driving it on the immediately following cycle.

Verification
REQ-028 SHALL cover: PULSE_LEN=4, accept i=5 -> y=16'h0020 for 4 cycles starting 1 cycle after acceptance, done high in 4th, then y=0.
REQ-029 SHALL cover: sweep i=0..15 with PULSE_LEN=1 -> y equals 1<<i each, one-hot check, 16 done pulses.
REQ-030 SHALL cover: en dropped in 2nd DRIVE cycle of i=9 -> y=0 next cycle, no done, i_ready=0 while en=0.
REQ-031 SHALL cover: rst asserted mid-DRIVE of i=15 -> next cycle y=0, busy=0, done=0, pending cleared.
REQ-032 SHALL cover: without DEC_QUEUE_EN, back-to-back i_valid with i=3 then i=12 -> i_ready=0 during DRIVE, one y=0 cycle between 16'h0008 and 16'h1000.
REQ-033 SHALL cover: with DEC_QUEUE_EN, i=3 then i=12 accepted during DRIVE -> y goes 16'h0008 to 16'h1000 with no gap, third code stalls with i_ready=0 until slot empties.

Source files
------------

// File: rtl/onehot_pulse_decoder_16_if.sv
// Handshake and output bundle for onehot_pulse_decoder_16.
// The master modport belongs to the code producer and consumer.
// The slave modport belongs to the decoder itself.
interface onehot_pulse_decoder_16_if;
  logic        en;
  logic        i_valid;
  logic        i_ready;
  logic [3:0]  i;
  logic [15:0] y;
  logic        busy;
  logic        done;

  modport master (
    output en,
    output i_valid,
    output i,
    input  i_ready,
    input  y,
    input  busy,
    input  done
  );

  modport slave (
    input  en,
    input  i_valid,
    input  i,
    output i_ready,
    output y,
    output busy,
    output done
  );
endinterface

// File: rtl/onehot_pulse_decoder_16.sv
// onehot_pulse_decoder_16: turns each accepted 4-bit code into a registered
// one-hot pulse on y, held for PULSE_LEN cycles.
//
// Optional feature: define DEC_QUEUE_EN to add a one-entry pending-code slot.
// With the slot, a code can be accepted while a pulse is being driven, and it
// follows the current pulse with no idle gap. Without the slot, the block
// refuses codes while driving, so consecutive pulses are separated by at
// least one cycle with y = 0.
//
// en low aborts the current pulse on the next cycle and drops any pending
// code. rst is synchronous, active-high, and overrides everything else.
module onehot_pulse_decoder_16 #(
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  onehot_pulse_decoder_16_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Value loaded into the hold counter. Counting reaches zero on the final
  // DRIVE cycle, so PULSE_LEN = 1 loads zero and finishes in the first cycle.
  localparam logic [7:0] RELOAD = 8'(PULSE_LEN - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [15:0] y_r, y_nx;
  logic        ready;
  logic        accept;

`ifdef DEC_QUEUE_EN
  logic        slot_vld, slot_vld_nx;
  logic [3:0]  slot_code, slot_code_nx;
`endif

  function automatic logic [15:0] decode(input logic [3:0] code);
    decode = 16'h0001 << code;
  endfunction

  // Ready: open in IDLE when enabled. With the slot, also open during DRIVE
  // while the slot is empty. Reset always closes it.
  always_comb begin
    ready = 1'b0;
    if (!rst && bus.en) begin
      if (state == IDLE) begin
        ready = 1'b1;
      end
`ifdef DEC_QUEUE_EN
      else begin
        ready = !slot_vld;
      end
`endif
    end
  end

  assign accept = bus.i_valid && ready;

  // Next-state logic for state, hold counter, output register and pending slot.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    y_nx         = y_r;
`ifdef DEC_QUEUE_EN
    slot_vld_nx  = slot_vld;
    slot_code_nx = slot_code;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = DRIVE;
          y_nx     = decode(bus.i);
          cnt_nx   = RELOAD;
        end
      end
      DRIVE: begin
        if (!bus.en) begin
          // Abort: this code never reaches its done cycle; pending code is dropped.
          state_nx    = IDLE;
          y_nx        = '0;
          cnt_nx      = '0;
`ifdef DEC_QUEUE_EN
          slot_vld_nx = 1'b0;
`endif
        end else if (cnt != 8'd0) begin
          cnt_nx = cnt - 8'd1;
`ifdef DEC_QUEUE_EN
          if (accept) begin
            slot_vld_nx  = 1'b1;
            slot_code_nx = bus.i;
          end
`endif
        end else begin
          // Final DRIVE cycle. Go idle unless another code follows directly.
          state_nx = IDLE;
          y_nx     = '0;
          cnt_nx   = '0;
`ifdef DEC_QUEUE_EN
          if (slot_vld) begin
            state_nx    = DRIVE;
            y_nx        = decode(slot_code);
            cnt_nx      = RELOAD;
            slot_vld_nx = 1'b0;
          end else if (accept) begin
            // A code taken in the final cycle goes straight to y.
            state_nx = DRIVE;
            y_nx     = decode(bus.i);
            cnt_nx   = RELOAD;
          end
`endif
        end
      end
      default: begin
        state_nx = IDLE;
        y_nx     = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register. Reset clears control and the visible output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      y_r      <= '0;
`ifdef DEC_QUEUE_EN
      slot_vld <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      y_r      <= y_nx;
`ifdef DEC_QUEUE_EN
      slot_vld <= slot_vld_nx;
`endif
    end
  end

`ifdef DEC_QUEUE_EN
  // Pending code payload. Its meaning is qualified by slot_vld, so it is not reset.
  always_ff @(posedge clk) begin
    slot_code <= slot_code_nx;
  end
`endif

  assign bus.i_ready = ready;
  assign bus.y       = y_r;
  assign bus.busy    = (state == DRIVE);
  assign bus.done    = (state == DRIVE) && (cnt == 8'd0);

endmodule

// File: tb/tb_onehot_pulse_decoder_16.sv
// Directed bench for onehot_pulse_decoder_16. Instance A uses PULSE_LEN=4.
// Instance B uses PULSE_LEN=1 for the code sweep.
// Inputs are driven 1 time unit after each rising edge.
// Outputs are sampled in the same window, before the next rising edge.
module tb_onehot_pulse_decoder_16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onehot_pulse_decoder_16_if a_if ();
  onehot_pulse_decoder_16_if b_if ();

  onehot_pulse_decoder_16 #(.PULSE_LEN(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  onehot_pulse_decoder_16 #(.PULSE_LEN(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_if.en = 1'b0; a_if.i_valid = 1'b0; a_if.i = 4'd0;
    b_if.en = 1'b0; b_if.i_valid = 1'b0; b_if.i = 4'd0;
    a_if.en = 1'b1;
    tick();
    tick();
    // Reset state: ready is held low even with en=1.
    chk("rst_y",     32'(a_if.y),       32'h0);
    chk("rst_busy",  32'(a_if.busy),    32'h0);
    chk("rst_done",  32'(a_if.done),    32'h0);
    chk("rst_ready", 32'(a_if.i_ready), 32'h0);

    rst = 1'b0;
    b_if.en = 1'b1;
    #1;
    chk("idle_ready", 32'(a_if.i_ready), 32'h1);
    chk("idle_y",     32'(a_if.y),       32'h0);

    // Code 5 with PULSE_LEN=4: four cycles of 0x0020, done in the 4th.
    a_if.i_valid = 1'b1; a_if.i = 4'd5;
    tick();
    a_if.i_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("c5_y%0d", k),    32'(a_if.y),    32'h0020);
      chk($sformatf("c5_busy%0d", k), 32'(a_if.busy), 32'h1);
      chk($sformatf("c5_done%0d", k), 32'(a_if.done), (k == 4) ? 32'h1 : 32'h0);
      tick();
    end
    chk("c5_after_y",    32'(a_if.y),    32'h0);
    chk("c5_after_busy", 32'(a_if.busy), 32'h0);

    // Sweep all codes with PULSE_LEN=1.
    for (int c = 0; c < 16; c++) begin
      b_if.i_valid = 1'b1; b_if.i = 4'(c);
      tick();
      b_if.i_valid = 1'b0;
      chk($sformatf("sw_y%0d", c),   32'(b_if.y),            32'(16'h0001 << c));
      chk($sformatf("sw_oh%0d", c),  32'($onehot(b_if.y)),   32'h1);
      chk($sformatf("sw_dn%0d", c),  32'(b_if.done),         32'h1);
      if (b_if.done === 1'b1) n_done++;
      tick();
      chk($sformatf("sw_gap%0d", c), 32'(b_if.y),            32'h0);
    end
    chk("sw_done_count", 32'(n_done), 32'd16);

    // en falls in the final DRIVE cycle: done still shows, then idle.
    a_if.i_valid = 1'b1; a_if.i = 4'd1;
    tick();
    a_if.i_valid = 1'b0;
    tick(); tick(); tick();
    a_if.en = 1'b0;
    #1;
    chk("enfin_done", 32'(a_if.done), 32'h1);
    chk("enfin_y",    32'(a_if.y),    32'h0002);
    tick();
    chk("enfin_after_y",    32'(a_if.y),    32'h0);
    chk("enfin_after_busy", 32'(a_if.busy), 32'h0);
    a_if.en = 1'b1;
    #1;

    // Abort code 9 in its 2nd DRIVE cycle.
    a_if.i_valid = 1'b1; a_if.i = 4'd9;
    tick();
    a_if.i_valid = 1'b0;
    chk("ab_y1", 32'(a_if.y), 32'h0200);
    tick();
    a_if.en = 1'b0;
    #1;
    chk("ab_ready_en0", 32'(a_if.i_ready), 32'h0);
    chk("ab_done_c2",   32'(a_if.done),    32'h0);
    tick();
    chk("ab_y",    32'(a_if.y),       32'h0);
    chk("ab_busy", 32'(a_if.busy),    32'h0);
    chk("ab_ready",32'(a_if.i_ready), 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ab_nodone%0d", k), 32'(a_if.done), 32'h0);
      tick();
    end
    a_if.en = 1'b1;
    #1;

    // Reset mid-DRIVE of code 15, with a second code offered (pending if slot exists).
    a_if.i_valid = 1'b1; a_if.i = 4'd15;
    tick();
    chk("rs_y1", 32'(a_if.y), 32'h8000);
    a_if.i = 4'd2;
    tick();
    a_if.i_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rs_ready", 32'(a_if.i_ready), 32'h0);
    tick();
    chk("rs_y",    32'(a_if.y),    32'h0);
    chk("rs_busy", 32'(a_if.busy), 32'h0);
    chk("rs_done", 32'(a_if.done), 32'h0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rs_clear_y%0d", k),    32'(a_if.y),    32'h0);
      chk($sformatf("rs_clear_busy%0d", k), 32'(a_if.busy), 32'h0);
      tick();
    end

`ifdef DEC_QUEUE_EN
    // Codes 3 and 12 back to back with no gap; a third code (7) stalls on the full slot.
    a_if.i_valid = 1'b1; a_if.i = 4'd3;
    tick();
    chk("q_y1",     32'(a_if.y),       32'h0008);
    chk("q_ready1", 32'(a_if.i_ready), 32'h1);
    a_if.i = 4'd12;
    tick();
    a_if.i = 4'd7;
    #1;
    chk("q_y2",     32'(a_if.y),       32'h0008);
    chk("q_ready2", 32'(a_if.i_ready), 32'h0);
    tick();
    chk("q_y3",     32'(a_if.y),       32'h0008);
    chk("q_ready3", 32'(a_if.i_ready), 32'h0);
    tick();
    chk("q_y4",     32'(a_if.y),       32'h0008);
    chk("q_done4",  32'(a_if.done),    32'h1);
    chk("q_ready4", 32'(a_if.i_ready), 32'h0);
    tick();
    chk("q_nogap_y",     32'(a_if.y),       32'h1000);
    chk("q_nogap_ready", 32'(a_if.i_ready), 32'h1);
    tick();
    a_if.i_valid = 1'b0;
    #1;
    chk("q_12_y2",    32'(a_if.y),       32'h1000);
    chk("q_12_ready", 32'(a_if.i_ready), 32'h0);
    tick(); tick();
    chk("q_12_done", 32'(a_if.done), 32'h1);
    tick();
    chk("q_7_y", 32'(a_if.y), 32'h0080);
    tick(); tick(); tick(); tick();
    chk("q_end_y", 32'(a_if.y), 32'h0);
`else
    // Codes 3 and 12 back to back: ready stays low while driving, one y=0 cycle between.
    a_if.i_valid = 1'b1; a_if.i = 4'd3;
    tick();
    a_if.i = 4'd12;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("nq_y%0d", k),     32'(a_if.y),       32'h0008);
      chk($sformatf("nq_ready%0d", k), 32'(a_if.i_ready), 32'h0);
      tick();
    end
    chk("nq_gap_y",     32'(a_if.y),       32'h0);
    chk("nq_gap_ready", 32'(a_if.i_ready), 32'h1);
    tick();
    a_if.i_valid = 1'b0;
    chk("nq_12_y", 32'(a_if.y), 32'h1000);
    tick(); tick(); tick(); tick();
    chk("nq_end_y", 32'(a_if.y), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
